window_3x3_gen: RTL and testbench

- Raster-order pixel stream to 3x3 neighbourhood window converter.
- Sits directly upstream of the 3x3 box-blur MAC; its out_window/out_valid feed the MAC's 72-bit pixel input and pixel-valid.
- Buffers the two previous image rows in internal line buffers.
- Emits one full window per accepted pixel once a complete 3x3 neighbourhood exists ("valid-only" windows, no border padding).

---
 rtl/window_3x3_gen.sv | 134 +++++++++++++
 tb/tb_window_3x3_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster pixel stream to 3x3 neighbourhood window converter.
// Two line buffers hold the previous rows. One window is emitted per accepted
// pixel once a full 3x3 neighbourhood exists; border windows are never produced.
// Optional build macro WINDOW_SOF_SYNC_EN adds in_sof, which forces the accepted
// pixel to be position (0,0) of a new frame.
//
// state  | meaning
// IDLE   | no pixel of the current frame accepted yet
// FILL   | rows 0 and 1 are arriving, outputs suppressed
// ACTIVE | row >= 2, windows emitted for col >= 2
module window_3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    input  logic                    in_valid,
`ifdef WINDOW_SOF_SYNC_EN
    input  logic                    in_sof,
`endif
    output logic [9*DATA_WIDTH-1:0] out_window,
    output logic                    out_valid,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [CW-1:0]           col, col_cur;
    logic [RW-1:0]           row, row_cur;
    logic [1:0]              state, state_n;
    logic                    sof;
    logic                    last_col, last_px, emit;
    logic [DATA_WIDTH-1:0]   lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]   lb0_rd, lb1_rd;
    logic [9*DATA_WIDTH-1:0] win, win_d;

`ifdef WINDOW_SOF_SYNC_EN
    assign sof = in_valid & in_sof;
`else
    assign sof = 1'b0;
`endif

    // Position of the pixel being accepted; a start-of-frame overrides the counters.
    always_comb begin
        col_cur  = sof ? '0 : col;
        row_cur  = sof ? '0 : row;
        last_col = (col_cur == COL_LAST);
        last_px  = last_col && (row_cur == ROW_LAST);
        emit     = in_valid && !sof && (state == ACTIVE) && (col_cur >= COL_TWO);
        lb0_rd   = lb0[col_cur];
        lb1_rd   = lb1[col_cur];
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_n = state;
        if (in_valid) begin
            if (sof) begin
                state_n = FILL;
            end else begin
                case (state)
                    IDLE:    state_n = FILL;
                    FILL:    if (last_col && row_cur == ROW_ONE) state_n = ACTIVE;
                    ACTIVE:  if (last_px) state_n = IDLE;
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // Next window: shift columns left and load the new right column top-to-bottom.
    always_comb begin
        win_d = win;
        for (int r = 0; r < 3; r++) begin
            win_d[(r*3)*DATA_WIDTH   +: DATA_WIDTH] = win[(r*3+1)*DATA_WIDTH +: DATA_WIDTH];
            win_d[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] = win[(r*3+2)*DATA_WIDTH +: DATA_WIDTH];
        end
        win_d[2*DATA_WIDTH +: DATA_WIDTH] = lb0_rd;
        win_d[5*DATA_WIDTH +: DATA_WIDTH] = lb1_rd;
        win_d[8*DATA_WIDTH +: DATA_WIDTH] = in_pixel;
    end

    // Position counters, sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            state      <= IDLE;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
        end else begin
            state      <= state_n;
            out_valid  <= emit;
            frame_done <= in_valid && last_px;
            if (emit) out_window <= win_d;
            if (in_valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
                end else begin
                    col <= col_cur + 1'b1;
                    row <= row_cur;
                end
            end
        end
    end

    // Line buffers: the row above moves down to lb0, the new pixel lands in lb1.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[col_cur] <= lb1_rd;
            lb1[col_cur] <= in_pixel;
        end
    end

    // Window shift register; contents are don't-care until the first emitted window.
    always_ff @(posedge clk) begin
        if (in_valid) win <= win_d;
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a 4x4 and a 3x3 instance driven from tasks, with a
// frame-image reference model predicting every output each cycle.
module tb_window_3x3_gen;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pix_a, pix_b;
    logic          vld_a, vld_b;
    logic [9*DW-1:0] win_a, win_b;
    logic          ov_a, ov_b, fd_a, fd_b;
`ifdef WINDOW_SOF_SYNC_EN
    logic          sof_a, sof_b;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .rst(rst), .in_pixel(pix_a), .in_valid(vld_a),
`ifdef WINDOW_SOF_SYNC_EN
        .in_sof(sof_a),
`endif
        .out_window(win_a), .out_valid(ov_a), .frame_done(fd_a));

    window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
        .clk(clk), .rst(rst), .in_pixel(pix_b), .in_valid(vld_b),
`ifdef WINDOW_SOF_SYNC_EN
        .in_sof(sof_b),
`endif
        .out_window(win_b), .out_valid(ov_b), .frame_done(fd_b));

    int checks = 0;
    int failures = 0;

    // reference model state, index 0 = 4x4 instance, 1 = 3x3 instance
    int            mw [2] = '{4, 3};
    int            mh [2] = '{4, 3};
    int            pos [2];
    logic [DW-1:0] img [2][4][4];
    logic [9*DW-1:0] ew [2];
    logic          eov [2];
    logic          efd [2];

    logic [9*DW-1:0] cap_a [$];
    logic [9*DW-1:0] cap_b [$];
    logic [9*DW-1:0] ref_seq [$];
    int nfd_a, nfd_b;

    task automatic chk(input string tag, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] win_of(input int base, input int w);
        logic [9*DW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(r*3+c)*DW +: DW] = DW'(base + r*w + c);
        return v;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            pos[u] = 0; ew[u] = '0; eov[u] = 1'b0; efd[u] = 1'b0;
        end
    endtask

    task automatic model_step(input int u, input bit v, input logic [DW-1:0] p, input bit s);
        int r, c;
        eov[u] = 1'b0;
        efd[u] = 1'b0;
        if (v) begin
            if (s) pos[u] = 0;
            r = pos[u] / mw[u];
            c = pos[u] % mw[u];
            img[u][r][c] = p;
            if (r >= 2 && c >= 2) begin
                eov[u] = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[u][(i*3+j)*DW +: DW] = img[u][r-2+i][c-2+j];
            end
            if (pos[u] == mw[u]*mh[u] - 1) efd[u] = 1'b1;
            pos[u] = (pos[u] + 1) % (mw[u]*mh[u]);
        end
    endtask

    task automatic cycle(input bit va, input logic [DW-1:0] pa, input bit sa,
                         input bit vb, input logic [DW-1:0] pb, input bit sb);
        @(negedge clk);
        vld_a = va; pix_a = pa;
        vld_b = vb; pix_b = pb;
`ifdef WINDOW_SOF_SYNC_EN
        sof_a = sa; sof_b = sb;
`endif
        @(posedge clk);
        #1;
        model_step(0, va, pa, sa);
        model_step(1, vb, pb, sb);
        chk("ov_a",  72'(ov_a), 72'(eov[0]));
        chk("fd_a",  72'(fd_a), 72'(efd[0]));
        chk("win_a", win_a, ew[0]);
        chk("ov_b",  72'(ov_b), 72'(eov[1]));
        chk("fd_b",  72'(fd_b), 72'(efd[1]));
        chk("win_b", win_b, ew[1]);
        if (ov_a) cap_a.push_back(win_a);
        if (ov_b) cap_b.push_back(win_b);
        if (fd_a) nfd_a++;
        if (fd_b) nfd_b++;
    endtask

    task automatic send_a(input int p, input bit s);
        cycle(1'b1, DW'(p), s, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_ov_a",  72'(ov_a), 72'(0));
        chk("rst_fd_a",  72'(fd_a), 72'(0));
        chk("rst_win_a", win_a, '0);
        chk("rst_ov_b",  72'(ov_b), 72'(0));
        chk("rst_win_b", win_b, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_caps();
        cap_a.delete(); cap_b.delete(); nfd_a = 0; nfd_b = 0;
    endtask

    initial begin
        rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; pix_a = '0; pix_b = '0;
`ifdef WINDOW_SOF_SYNC_EN
        sof_a = 1'b0; sof_b = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // 4x4 frame, continuous
        clear_caps();
        for (int p = 1; p <= 16; p++) send_a(p, 1'b0);
        idle();
        chk("cont_count", 72'(cap_a.size()), 72'(4));
        chk("cont_fd",    72'(nfd_a), 72'(1));
        if (cap_a.size() == 4) begin
            chk("cont_first", cap_a[0], win_of(1, 4));
            chk("cont_last",  cap_a[3], win_of(6, 4));
        end
        ref_seq = cap_a;

        // same frame with random gaps
        clear_caps();
        for (int p = 1; p <= 16; p++) begin
            send_a(p, 1'b0);
            repeat ($urandom_range(0, 3)) idle();
        end
        idle();
        chk("gap_count", 72'(cap_a.size()), 72'(4));
        chk("gap_fd",    72'(nfd_a), 72'(1));
        for (int i = 0; i < 4; i++)
            if (i < cap_a.size() && i < ref_seq.size()) chk("gap_seq", cap_a[i], ref_seq[i]);

        // back-to-back frames
        clear_caps();
        for (int p = 1; p <= 16; p++) send_a(p, 1'b0);
        for (int p = 101; p <= 116; p++) send_a(p, 1'b0);
        idle();
        chk("b2b_count", 72'(cap_a.size()), 72'(8));
        chk("b2b_fd",    72'(nfd_a), 72'(2));
        if (cap_a.size() >= 5) chk("b2b_fifth", cap_a[4], win_of(101, 4));

        // reset mid-frame
        for (int p = 1; p <= 7; p++) send_a(p, 1'b0);
        do_reset();
        clear_caps();
        for (int p = 1; p <= 16; p++) send_a(p, 1'b0);
        idle();
        chk("rstmid_count", 72'(cap_a.size()), 72'(4));
        if (cap_a.size() > 0) chk("rstmid_first", cap_a[0], win_of(1, 4));

        // 3x3 frame on the second instance
        clear_caps();
        for (int p = 1; p <= 9; p++) cycle(1'b0, '0, 1'b0, 1'b1, DW'(p), 1'b0);
        idle();
        chk("sq3_count", 72'(cap_b.size()), 72'(1));
        chk("sq3_fd",    72'(nfd_b), 72'(1));
        if (cap_b.size() > 0) chk("sq3_win", cap_b[0], win_of(1, 3));

        // random pixels and gaps on both instances
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, DW'($urandom), 1'b0,
                  $urandom_range(0, 2) != 0, DW'($urandom), 1'b0);

`ifdef WINDOW_SOF_SYNC_EN
        // partial frame then a forced start of frame
        do_reset();
        clear_caps();
        for (int p = 1; p <= 6; p++) send_a(p, 1'b0);
        send_a(1, 1'b1);
        for (int p = 2; p <= 16; p++) send_a(p, 1'b0);
        idle();
        chk("sof_count", 72'(cap_a.size()), 72'(4));
        chk("sof_fd",    72'(nfd_a), 72'(1));
        if (cap_a.size() > 0) chk("sof_first", cap_a[0], win_of(1, 4));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
